printf_line_buf: RTL and testbench

PRINTF_LINE_BUF -- requirements
Module: printf_line_buf

---
 rtl/printf_pkg.sv | 20 ++
 rtl/line_fifo.sv | 59 +++++
 rtl/printf_line_buf.sv | 158 +++++++++++++++
 tb/tb_printf_line_buf.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/printf_pkg.sv
// Shared constants and types for the printf line buffer: terminator bytes,
// per-channel state encoding and overflow-mode selectors.
package printf_pkg;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  localparam int OVF_TRUNC = 0;
  localparam int OVF_WRAP  = 1;

  typedef enum logic {
    FILL = 1'b0,
    PEND = 1'b1
  } ch_state_e;

  function automatic logic is_term(input logic [7:0] b);
    return (b == ASCII_LF) || (b == ASCII_CR);
  endfunction

endpackage

// File: rtl/line_fifo.sv
// Generic synchronous first-word-fall-through FIFO; head entry is visible on
// dout whenever empty is low.
module line_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // When full, a write may still land in the slot being vacated by the pop.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/printf_line_buf.sv
// Collects per-channel printf characters into line buffers and hands completed
// lines, round-robin across channels, to a shared FWFT line queue.
module printf_line_buf
  import printf_pkg::*;
#(
  parameter int LINE_LEN   = 64,
  parameter int CH_NUM     = 2,
  parameter int LINE_DEPTH = 4,
  parameter int OVF_MODE   = 0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [CH_NUM-1:0]                        ch_valid,
  input  logic [CH_NUM*8-1:0]                      ch_data,
  output logic [CH_NUM-1:0]                        ch_ready,
  output logic                                     line_valid,
  input  logic                                     line_ready,
  output logic [LINE_LEN*8-1:0]                    line_data,
  output logic [$clog2(LINE_LEN+1)-1:0]            line_len,
  output logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] line_ch,
  output logic                                     line_trunc
);

  localparam int LW = $clog2(LINE_LEN + 1);
  localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int DW = LINE_LEN * 8;
  localparam int EW = DW + LW + CW + 1;

  logic [CH_NUM-1:0] pend, gnt, trunc_vec;
  logic [DW-1:0]     buf_arr [CH_NUM];
  logic [LW-1:0]     len_arr [CH_NUM];

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : gen_ch
    ch_state_e     state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [DW-1:0] buf_q, buf_d;
    logic          trunc_q, trunc_d;
    logic [7:0]    ch_byte;

    assign ch_byte = ch_data[gi*8 +: 8];

    always_comb begin
      state_d = state_q;
      len_d   = len_q;
      buf_d   = buf_q;
      trunc_d = trunc_q;
      if (state_q == PEND) begin
        if (gnt[gi]) begin
          state_d = FILL;
          len_d   = '0;
          buf_d   = '0;
          trunc_d = 1'b0;
        end
      end else if (ch_valid[gi]) begin
        if (is_term(ch_byte)) begin
          if (len_q != '0) state_d = PEND;
        end else if (len_q == LW'(LINE_LEN)) begin
          trunc_d = (OVF_MODE == OVF_TRUNC);
        end else begin
          // First character lands in the most-significant byte.
          for (int p = 0; p < LINE_LEN; p++) begin
            if (len_q == LW'(p)) buf_d[(LINE_LEN-1-p)*8 +: 8] = ch_byte;
          end
          len_d = len_q + LW'(1);
          if ((OVF_MODE == OVF_WRAP) && (len_q == LW'(LINE_LEN - 1))) state_d = PEND;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= FILL;
        len_q   <= '0;
        buf_q   <= '0;
        trunc_q <= 1'b0;
      end else begin
        state_q <= state_d;
        len_q   <= len_d;
        buf_q   <= buf_d;
        trunc_q <= trunc_d;
      end
    end

    assign ch_ready[gi]  = (state_q == FILL);
    assign pend[gi]      = (state_q == PEND);
    assign buf_arr[gi]   = buf_q;
    assign len_arr[gi]   = len_q;
    assign trunc_vec[gi] = trunc_q;
  end

  logic [CW-1:0] rr_q, rr_d, sel_idx;
  logic          found, push, pop, fifo_empty, fifo_full;
  logic [DW-1:0] push_buf;
  logic [LW-1:0] push_len;
  logic          push_trunc;
  logic [EW-1:0] fifo_din, fifo_dout;

  // Scan channels starting from the round-robin pointer; first PEND one wins.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      for (int j = 0; j < CH_NUM; j++) begin
        if (!found && pend[j] && (j == (int'(rr_q) + i) % CH_NUM)) begin
          found   = 1'b1;
          sel_idx = CW'(j);
        end
      end
    end
  end

  assign pop  = line_valid & line_ready;
  assign push = found & (~fifo_full | pop);

  always_comb begin
    gnt        = '0;
    push_buf   = '0;
    push_len   = '0;
    push_trunc = 1'b0;
    for (int j = 0; j < CH_NUM; j++) begin
      if (sel_idx == CW'(j)) begin
        gnt[j]     = push;
        push_buf   = buf_arr[j];
        push_len   = len_arr[j];
        push_trunc = trunc_vec[j];
      end
    end
    rr_d = push ? CW'((int'(sel_idx) + 1) % CH_NUM) : rr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end

  assign fifo_din = {push_buf, push_len, sel_idx, push_trunc};

  line_fifo #(
    .WIDTH(EW),
    .DEPTH(LINE_DEPTH)
  ) u_line_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (fifo_din),
    .pop  (pop),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  assign line_valid = ~fifo_empty;
  assign line_data  = line_valid ? fifo_dout[EW-1 -: DW]      : '0;
  assign line_len   = line_valid ? fifo_dout[CW+1 +: LW]      : '0;
  assign line_ch    = line_valid ? fifo_dout[1 +: CW]         : '0;
  assign line_trunc = line_valid ? fifo_dout[0]               : 1'b0;

endmodule

// File: tb/tb_printf_line_buf.sv
// Self-checking bench for printf_line_buf: three configurations (64/trunc,
// 4/trunc, 4/wrap) selected one at a time through a shared driver.
module tb_printf_line_buf;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  ch_valid;
  logic [15:0] ch_data;
  logic        line_ready;
  int          sel;

  logic [1:0]   a_ready, t_ready, w_ready;
  logic         a_valid, t_valid, w_valid;
  logic [511:0] a_data;
  logic [31:0]  t_data, w_data;
  logic [6:0]   a_len;
  logic [2:0]   t_len, w_len;
  logic [0:0]   a_ch, t_ch, w_ch;
  logic         a_tr, t_tr, w_tr;
  logic [1:0]   a_cv, t_cv, w_cv;
  logic         a_lr, t_lr, w_lr;

  assign a_cv = (sel == 0) ? ch_valid : 2'b00;
  assign t_cv = (sel == 1) ? ch_valid : 2'b00;
  assign w_cv = (sel == 2) ? ch_valid : 2'b00;
  assign a_lr = (sel == 0) & line_ready;
  assign t_lr = (sel == 1) & line_ready;
  assign w_lr = (sel == 2) & line_ready;

  printf_line_buf #(.LINE_LEN(64), .CH_NUM(2), .LINE_DEPTH(4), .OVF_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .ch_valid(a_cv), .ch_data(ch_data), .ch_ready(a_ready),
    .line_valid(a_valid), .line_ready(a_lr), .line_data(a_data), .line_len(a_len),
    .line_ch(a_ch), .line_trunc(a_tr));

  printf_line_buf #(.LINE_LEN(4), .CH_NUM(2), .LINE_DEPTH(4), .OVF_MODE(0)) dut_t (
    .clk(clk), .rst(rst), .ch_valid(t_cv), .ch_data(ch_data), .ch_ready(t_ready),
    .line_valid(t_valid), .line_ready(t_lr), .line_data(t_data), .line_len(t_len),
    .line_ch(t_ch), .line_trunc(t_tr));

  printf_line_buf #(.LINE_LEN(4), .CH_NUM(2), .LINE_DEPTH(4), .OVF_MODE(1)) dut_w (
    .clk(clk), .rst(rst), .ch_valid(w_cv), .ch_data(ch_data), .ch_ready(w_ready),
    .line_valid(w_valid), .line_ready(w_lr), .line_data(w_data), .line_len(w_len),
    .line_ch(w_ch), .line_trunc(w_tr));

  logic [1:0]   cur_ready;
  logic         cur_valid, cur_tr;
  logic [511:0] cur_data;
  logic [6:0]   cur_len;
  logic [0:0]   cur_ch;

  always_comb begin
    cur_ready = a_ready; cur_valid = a_valid; cur_data = a_data;
    cur_len   = a_len;   cur_ch    = a_ch;    cur_tr   = a_tr;
    if (sel == 1) begin
      cur_ready = t_ready; cur_valid = t_valid; cur_data = {480'b0, t_data};
      cur_len   = {4'b0, t_len}; cur_ch = t_ch; cur_tr = t_tr;
    end else if (sel == 2) begin
      cur_ready = w_ready; cur_valid = w_valid; cur_data = {480'b0, w_data};
      cur_len   = {4'b0, w_len}; cur_ch = w_ch; cur_tr = w_tr;
    end
  end

  typedef struct {
    logic [511:0] data;
    int           len;
    int           ch;
    bit           tr;
  } line_t;

  typedef struct {
    int           sel;
    logic [127:0] stim;
    int           n;
    int           cnt;
    logic [127:0] e0;
    int           e0len;
    bit           e0tr;
    logic [127:0] e1;
    int           e1len;
    bit           e1tr;
  } vec_t;

  line_t      got_q[$];
  line_t      exp_q[2][$];
  logic [7:0] byte_q[2][$];
  int         tests = 0;
  int         fails = 0;

  always @(negedge clk) begin
    if (cur_valid && line_ready)
      got_q.push_back('{cur_data, int'(cur_len), int'(cur_ch), cur_tr});
  end

  task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_line(logic [127:0] txt, int n, int L);
    logic [511:0] r = '0;
    for (int i = 0; i < n; i++) r[(L-1-i)*8 +: 8] = txt[(n-1-i)*8 +: 8];
    return r;
  endfunction

  function automatic line_t pack_line(logic [7:0] q[$], int L, int k, bit tr);
    line_t e;
    e.data = '0;
    foreach (q[p]) e.data[(L-1-p)*8 +: 8] = q[p];
    e.len = q.size();
    e.ch  = k;
    e.tr  = tr;
    return e;
  endfunction

  // Reference: apply the line-building rules to a channel's whole byte stream.
  task automatic model_ch(int k, int L, int mode, logic [7:0] s[$]);
    logic [7:0] cur[$];
    bit tr = 1'b0;
    foreach (s[i]) begin
      if (s[i] == 8'h0A || s[i] == 8'h0D) begin
        if (cur.size() > 0) begin
          exp_q[k].push_back(pack_line(cur, L, k, tr));
          cur.delete(); tr = 1'b0;
        end
      end else if (cur.size() < L) begin
        cur.push_back(s[i]);
        if (mode == 1 && cur.size() == L) begin
          exp_q[k].push_back(pack_line(cur, L, k, tr));
          cur.delete(); tr = 1'b0;
        end
      end else begin
        tr = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ch_valid = 2'b00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_byte(int k, logic [7:0] b);
    bit acc = 1'b0;
    int guard = 0;
    ch_valid[k] = 1'b1;
    ch_data[k*8 +: 8] = b;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = cur_ready[k];
      tick();
      guard++;
    end
    ch_valid[k] = 1'b0;
    if (!acc) begin
      tests++; fails++;
      $display("FAIL send_timeout ch%0d: byte %0h not accepted, required within 200 cycles", k, b);
    end
  endtask

  task automatic send_str(int k, logic [127:0] s, int n);
    for (int i = 0; i < n; i++) send_byte(k, s[(n-1-i)*8 +: 8]);
  endtask

  task automatic wait_lines(int n, int budget);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    tests++;
    if (got_q.size() < n) begin
      fails++;
      $display("FAIL wait_lines: got %0d lines, required %0d", got_q.size(), n);
    end
  endtask

  task automatic chk_line(string nm, line_t g, logic [511:0] ed, int el, int ech, bit etr);
    chk({nm, "_data"}, g.data, ed);
    chk({nm, "_len"}, 512'(g.len), 512'(el));
    chk({nm, "_ch"}, 512'(g.ch), 512'(ech));
    chk({nm, "_trunc"}, 512'(g.tr), 512'(etr));
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  vec_t         vt[8];
  logic [23:0]  ltxt;
  logic [127:0] ed_txt;

  initial begin
    rst = 1'b1; ch_valid = 2'b00; ch_data = '0; line_ready = 1'b0; sel = 0;

    vt[0] = '{1, "ABCDEF\n",    7, 1, "ABCD", 4, 1'b1, 128'h0, 0, 1'b0};
    vt[1] = '{2, "ABCDEF\n",    7, 2, "ABCD", 4, 1'b0, "EF",   2, 1'b0};
    vt[2] = '{0, "\015\n",      2, 0, 128'h0, 0, 1'b0, 128'h0, 0, 1'b0};
    vt[3] = '{0, "\n\n",        2, 0, 128'h0, 0, 1'b0, 128'h0, 0, 1'b0};
    vt[4] = '{0, "ok\015\n",    4, 1, "ok",   2, 1'b0, 128'h0, 0, 1'b0};
    vt[5] = '{1, "ABCD\n",      5, 1, "ABCD", 4, 1'b0, 128'h0, 0, 1'b0};
    vt[6] = '{2, "ABCD\n",      5, 1, "ABCD", 4, 1'b0, 128'h0, 0, 1'b0};
    vt[7] = '{1, "WXYZQ\nhi\n", 9, 2, "WXYZ", 4, 1'b1, "hi",   2, 1'b0};

    // Reset state, sampled while reset is still asserted.
    tick();
    @(negedge clk);
    chk("rst_ch_ready", 512'(cur_ready), 512'(2'b11));
    chk("rst_line_valid", 512'(cur_valid), 512'(0));
    chk("rst_line_data", cur_data, 512'(0));
    chk("rst_line_len", 512'(cur_len), 512'(0));
    chk("rst_line_ch", 512'(cur_ch), 512'(0));
    chk("rst_line_trunc", 512'(cur_tr), 512'(0));
    tick();
    rst = 1'b0;

    // "Hi\n" at edges 1-3: line visible only after edge 4.
    line_ready = 1'b1;
    send_str(0, "Hi\n", 3);
    @(negedge clk);
    chk("hi_not_yet_valid", 512'(cur_valid), 512'(0));
    tick();
    @(negedge clk);
    chk("hi_valid", 512'(cur_valid), 512'(1));
    chk("hi_data", cur_data, mk_line("Hi", 2, 64));
    chk("hi_len", 512'(cur_len), 512'(2));
    chk("hi_ch", 512'(cur_ch), 512'(0));
    chk("hi_trunc", 512'(cur_tr), 512'(0));
    tick();

    for (int r = 0; r < 8; r++) begin
      int L;
      sel = vt[r].sel;
      L = (sel == 0) ? 64 : 4;
      do_reset();
      got_q.delete();
      line_ready = 1'b1;
      send_str(0, vt[r].stim, vt[r].n);
      if (vt[r].cnt > 0) wait_lines(vt[r].cnt, 50);
      repeat (6) tick();
      chk($sformatf("row%0d_count", r), 512'(got_q.size()), 512'(vt[r].cnt));
      for (int e = 0; e < vt[r].cnt; e++) begin
        if (e < got_q.size()) begin
          ed_txt = (e == 0) ? vt[r].e0 : vt[r].e1;
          chk_line($sformatf("row%0d_line%0d", r, e), got_q[e],
                   mk_line(ed_txt, (e == 0) ? vt[r].e0len : vt[r].e1len, L),
                   (e == 0) ? vt[r].e0len : vt[r].e1len, 0,
                   (e == 0) ? vt[r].e0tr : vt[r].e1tr);
        end
      end
    end

    // Round-robin: simultaneous terminators, then rotate priority to ch1.
    sel = 0;
    do_reset();
    got_q.delete();
    line_ready = 1'b1;
    fork
      send_str(0, "X\n", 2);
      send_str(1, "Y\n", 2);
    join
    wait_lines(2, 50);
    if (got_q.size() >= 2) begin
      chk("arb1_first_ch", 512'(got_q[0].ch), 512'(0));
      chk("arb1_second_ch", 512'(got_q[1].ch), 512'(1));
      chk("arb1_second_data", got_q[1].data, mk_line("Y", 1, 64));
    end
    repeat (3) tick();
    got_q.delete();
    send_str(0, "Z\n", 2);
    wait_lines(1, 50);
    repeat (3) tick();
    got_q.delete();
    fork
      send_str(0, "X\n", 2);
      send_str(1, "Y\n", 2);
    join
    wait_lines(2, 50);
    if (got_q.size() >= 2) begin
      chk("arb2_first_ch", 512'(got_q[0].ch), 512'(1));
      chk("arb2_second_ch", 512'(got_q[1].ch), 512'(0));
    end
    repeat (3) tick();

    // Backpressure: five lines with the consumer stalled.
    do_reset();
    got_q.delete();
    line_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ltxt = {"L", 8'(48 + i), 8'h0A};
      send_str(0, {104'h0, ltxt}, 3);
    end
    repeat (3) tick();
    @(negedge clk);
    chk("bp_ch_ready_held", 512'(cur_ready[0]), 512'(0));
    chk("bp_line_valid", 512'(cur_valid), 512'(1));
    @(posedge clk);
    #1;
    line_ready = 1'b1;
    tick();
    line_ready = 1'b0;
    @(negedge clk);
    chk("bp_ch_ready_released", 512'(cur_ready[0]), 512'(1));
    @(posedge clk);
    #1;
    line_ready = 1'b1;
    wait_lines(5, 50);
    repeat (3) tick();
    chk("bp_count", 512'(got_q.size()), 512'(5));
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) begin
        ltxt = {8'h00, "L", 8'(48 + i)};
        chk($sformatf("bp_order%0d", i), got_q[i].data, mk_line({104'h0, ltxt}, 2, 64));
      end
    end

    // Reset mid-line, with a byte offered on the reset edge.
    do_reset();
    got_q.delete();
    line_ready = 1'b1;
    send_str(0, "AB", 2);
    rst = 1'b1;
    ch_valid[0] = 1'b1;
    ch_data[7:0] = "Z";
    tick();
    rst = 1'b0;
    ch_valid = 2'b00;
    @(negedge clk);
    chk("midrst_ch_ready", 512'(cur_ready), 512'(2'b11));
    chk("midrst_line_valid", 512'(cur_valid), 512'(0));
    @(posedge clk);
    #1;
    send_str(0, "C\n", 2);
    wait_lines(1, 50);
    repeat (4) tick();
    chk("midrst_count", 512'(got_q.size()), 512'(1));
    if (got_q.size() >= 1) chk_line("midrst_line", got_q[0], mk_line("C", 1, 64), 1, 0, 1'b0);

    // Randomised traffic on both channels against the reference model.
    for (int s = 0; s < 3; s++) begin
      int L, mode, nl, total, guard;
      sel  = s;
      L    = (s == 0) ? 64 : 4;
      mode = (s == 2) ? 1 : 0;
      nl   = (s == 0) ? 6 : 12;
      do_reset();
      got_q.delete();
      for (int k = 0; k < 2; k++) begin
        byte_q[k].delete();
        exp_q[k].delete();
        for (int l = 0; l < nl; l++) begin
          int n, t;
          n = $urandom_range(0, L + 3);
          for (int c = 0; c < n; c++) byte_q[k].push_back(8'(97 + $urandom_range(0, 25)));
          t = $urandom_range(0, 2);
          if (t == 0) byte_q[k].push_back(8'h0A);
          else if (t == 1) byte_q[k].push_back(8'h0D);
          else begin byte_q[k].push_back(8'h0D); byte_q[k].push_back(8'h0A); end
        end
        model_ch(k, L, mode, byte_q[k]);
      end
      total = exp_q[0].size() + exp_q[1].size();
      guard = 0;
      while ((byte_q[0].size() > 0 || byte_q[1].size() > 0) && guard < 20000) begin
        for (int k = 0; k < 2; k++) begin
          if (byte_q[k].size() > 0 && $urandom_range(0, 3) != 0) begin
            ch_valid[k] = 1'b1;
            ch_data[k*8 +: 8] = byte_q[k][0];
          end else begin
            ch_valid[k] = 1'b0;
          end
        end
        line_ready = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        for (int k = 0; k < 2; k++)
          if (ch_valid[k] && cur_ready[k]) void'(byte_q[k].pop_front());
        if (!cur_valid)
          chk($sformatf("rand%0d_idle_zero", s),
              cur_data | 512'({cur_len, cur_ch, cur_tr}), 512'(0));
        tick();
        guard++;
      end
      ch_valid = 2'b00;
      line_ready = 1'b1;
      wait_lines(total, 2000);
      repeat (5) tick();
      chk($sformatf("rand%0d_count", s), 512'(got_q.size()), 512'(total));
      foreach (got_q[i]) begin
        line_t e;
        int    gc;
        gc = got_q[i].ch;
        if (exp_q[gc].size() > 0) begin
          e = exp_q[gc].pop_front();
          chk_line($sformatf("rand%0d_line%0d", s, i), got_q[i], e.data, e.len, e.ch, e.tr);
        end else begin
          tests++; fails++;
          $display("FAIL rand%0d_extra_line: got unexpected line on ch%0d, required none", s, gc);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
